// File: rtl/i2s_receiver.sv
// I2S receiver: samples an external ADC bit stream and presents left/right sample pairs.
// Latency: a pair appears about 4 clk cycles after the bclk edge that ends its right word.
// Backpressure: out_stb holds until out_ack; a pair completing while still unacknowledged is dropped with overrun_out.
module i2s_receiver #(
  parameter int WIDTH     = 24,
  parameter int SCLK_HALF = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bclk_in,
  input  logic             lrclk_in,
  input  logic             dout_in,
  output logic             sclk_out,
  output logic [WIDTH-1:0] left_out,
  output logic [WIDTH-1:0] right_out,
  output logic             out_stb,
  input  logic             out_ack,
  output logic             overrun_out,
  output logic             frame_err_out
);

  localparam int CW  = $clog2(WIDTH + 1);
  localparam int SCW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [CW-1:0]  FULL    = CW'(WIDTH);
  localparam logic [SCW-1:0] SC_WRAP = SCW'(SCLK_HALF - 1);

  typedef enum logic [1:0] {HUNT, LEFT, RIGHT} state_t;

  // Synchroniser stages; bclk has one extra stage for edge detection
  logic r_bclk_s1, r_bclk_s2, r_bclk_s3;
  logic r_lr_s1, r_lr_s2;
  logic r_dat_s1, r_dat_s2;

  // Word assembly state
  state_t           r_state;
  logic             r_lr_prev;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_left_hold;
  logic             r_left_vld;
  logic             r_first;     // first word after leaving HUNT may be partial; never flag it

  logic [SCW-1:0]   r_sclk_cnt;

  logic w_bclk_rise;
  logic w_lr_chg;
  logic w_word_end;
  logic w_word_full;
  logic w_pair_done;
  logic w_bad_word;

  assign w_bclk_rise = r_bclk_s2 & ~r_bclk_s3;
  assign w_lr_chg    = r_lr_s2 ^ r_lr_prev;
  assign w_word_end  = w_bclk_rise & w_lr_chg;
  assign w_word_full = (r_cnt == FULL);
  assign w_pair_done = w_word_end & (r_state == RIGHT) & w_word_full & r_left_vld;
  assign w_bad_word  = w_word_end & (r_state != HUNT) & ~w_word_full & ~r_first;

  // Bring the asynchronous I2S lines into the clk domain, all with equal depth
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bclk_s1 <= 1'b0;
      r_bclk_s2 <= 1'b0;
      r_bclk_s3 <= 1'b0;
      r_lr_s1   <= 1'b0;
      r_lr_s2   <= 1'b0;
      r_dat_s1  <= 1'b0;
      r_dat_s2  <= 1'b0;
    end else begin
      r_bclk_s1 <= bclk_in;
      r_bclk_s2 <= r_bclk_s1;
      r_bclk_s3 <= r_bclk_s2;
      r_lr_s1   <= lrclk_in;
      r_lr_s2   <= r_lr_s1;
      r_dat_s1  <= dout_in;
      r_dat_s2  <= r_dat_s1;
    end
  end

  // Free-running ADC system clock, 50% duty at clk/(2*SCLK_HALF)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_cnt <= '0;
      sclk_out   <= 1'b0;
    end else if (r_sclk_cnt == SC_WRAP) begin
      r_sclk_cnt <= '0;
      sclk_out   <= ~sclk_out;
    end else begin
      r_sclk_cnt <= r_sclk_cnt + SCW'(1);
    end
  end

  // Channel FSM: shift bits on bclk rise, close words on lrclk change (1-bit I2S delay)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= HUNT;
      r_lr_prev     <= 1'b0;
      r_shift       <= '0;
      r_cnt         <= '0;
      r_left_hold   <= '0;
      r_left_vld    <= 1'b0;
      r_first       <= 1'b0;
      frame_err_out <= 1'b0;
    end else begin
      frame_err_out <= w_bad_word;
      if (w_bclk_rise) begin
        r_lr_prev <= r_lr_s2;
        if (!w_lr_chg) begin
          // Bits beyond WIDTH are slot padding and are ignored
          if (r_cnt < FULL) begin
            r_shift <= {r_shift[WIDTH-2:0], r_dat_s2};
            r_cnt   <= r_cnt + CW'(1);
          end
        end else begin
          r_cnt   <= '0;
          r_shift <= '0;
          unique case (r_state)
            HUNT: begin
              r_state <= r_lr_s2 ? RIGHT : LEFT;
              r_first <= 1'b1;
            end
            LEFT: begin
              r_state <= RIGHT;
              r_first <= 1'b0;
              if (w_word_full) begin
                r_left_hold <= r_shift;
                r_left_vld  <= 1'b1;
              end else begin
                r_left_vld  <= 1'b0;
              end
            end
            RIGHT: begin
              // A left word is paired with at most one right word
              r_state    <= LEFT;
              r_first    <= 1'b0;
              r_left_vld <= 1'b0;
            end
            default: r_state <= HUNT;
          endcase
        end
      end
    end
  end

  // Output holding stage with strobe/ack handshake and overrun detection
  always_ff @(posedge clk) begin
    if (rst) begin
      left_out    <= '0;
      right_out   <= '0;
      out_stb     <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      overrun_out <= 1'b0;
      if (w_pair_done) begin
        if (!out_stb || out_ack) begin
          left_out  <= r_left_hold;
          right_out <= r_shift;
          out_stb   <= 1'b1;
        end else begin
          overrun_out <= 1'b1;
        end
      end else if (out_stb && out_ack) begin
        out_stb <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: I2S frames are generated as bit-level slots, expected pairs
// and error counts are derived from slot lengths and kept in a queue-based scoreboard.
module tb_i2s_receiver;

  localparam int W  = 24;
  localparam int SH = 6;
  localparam int BH = 6;   // bclk half period in clk cycles

  logic         clk = 1'b0;
  logic         rst;
  logic         bclk_in, lrclk_in, dout_in, out_ack;
  logic         sclk_out, out_stb, overrun_out, frame_err_out;
  logic [W-1:0] left_out, right_out;

  i2s_receiver #(.WIDTH(W), .SCLK_HALF(SH)) dut (
    .clk(clk), .rst(rst), .bclk_in(bclk_in), .lrclk_in(lrclk_in), .dout_in(dout_in),
    .sclk_out(sclk_out), .left_out(left_out), .right_out(right_out), .out_stb(out_stb),
    .out_ack(out_ack), .overrun_out(overrun_out), .frame_err_out(frame_err_out)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] l; logic [W-1:0] r; } pair_t;
  typedef struct {
    logic [W-1:0] l;
    logic [W-1:0] r;
    int           llen;
    int           rlen;
    bit           exp_pair;
    bit           exp_lerr;
    bit           exp_rerr;
  } frame_t;

  pair_t        exp_q[$];
  pair_t        mon_e, mon_prev;
  int           checks = 0, fails = 0;
  int           n_obs = 0, n_err = 0, n_ovr = 0, exp_err_tot = 0;
  logic         mon_prev_stb = 1'b0, mon_prev_ack = 1'b0;
  logic         sim_stb;
  logic [W-1:0] sim_l, sim_r;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One channel slot: change edge first, then MSB-first data, then random padding
  task automatic send_slot(input logic ch, input logic [W-1:0] w, input int len, input bit sim);
    for (int k = 0; k < len; k++) begin
      bclk_in  = 1'b0;
      lrclk_in = ch;
      dout_in  = (k >= 1 && k <= W) ? w[W-k] : 1'($urandom);
      tick(BH);
      bclk_in = 1'b1;
      if (sim && k == 0) begin
        tick(2);
        out_ack = 1'b1;
        tick(1);
        sim_stb = out_stb;
        sim_l   = left_out;
        sim_r   = right_out;
        out_ack = 1'b0;
        tick(BH - 3);
      end else begin
        tick(BH);
      end
    end
  endtask

  task automatic send_frame(input frame_t f, input bit sim);
    if (f.exp_pair) exp_q.push_back('{f.l, f.r});
    exp_err_tot += int'(f.llen <= W) + int'(f.rlen <= W);
    send_slot(1'b0, f.l, f.llen, sim);
    send_slot(1'b1, f.r, f.rlen, 1'b0);
  endtask

  function automatic frame_t rand_frame(input bit allow_short);
    frame_t f;
    f.l    = W'($urandom);
    f.r    = W'($urandom);
    f.llen = (allow_short && $urandom_range(0, 3) == 0) ? int'($urandom_range(8, W)) : int'($urandom_range(W + 1, 32));
    f.rlen = (allow_short && $urandom_range(0, 3) == 0) ? int'($urandom_range(8, W)) : int'($urandom_range(W + 1, 32));
    f.exp_lerr = (f.llen <= W);
    f.exp_rerr = (f.rlen <= W);
    f.exp_pair = !f.exp_lerr && !f.exp_rerr;
    return f;
  endfunction

  // Output monitor: scoreboard on accepted pairs, hold stability, pulse counting
  always @(negedge clk) begin
    if (rst) begin
      mon_prev_stb = 1'b0;
      mon_prev_ack = 1'b0;
    end else begin
      if (out_stb && mon_prev_stb && !mon_prev_ack) begin
        chk("hold_left", left_out, mon_prev.l);
        chk("hold_right", right_out, mon_prev.r);
      end
      if (out_stb && out_ack) begin
        n_obs++;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_pair: got %h/%h expected none", left_out, right_out);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pair_left", left_out, mon_e.l);
          chk("pair_right", right_out, mon_e.r);
        end
      end
      if (overrun_out)   n_ovr++;
      if (frame_err_out) n_err++;
      mon_prev_stb = out_stb;
      mon_prev_ack = out_ack;
      mon_prev.l   = left_out;
      mon_prev.r   = right_out;
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    frame_t tbl[7];
    frame_t fa, fb, fc, fd, fe, fr;
    int pairs_before, err_run, n_obs_rst;

    tbl[0] = '{24'h123456, 24'hABCDEF, 32, 32, 1'b0, 1'b0, 1'b0};  // swallowed by HUNT
    tbl[1] = '{24'h123456, 24'hABCDEF, 32, 32, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{24'h800001, 24'h7FFFFE, 25, 25, 1'b1, 1'b0, 1'b0};  // shortest legal slot
    tbl[3] = '{24'h5A5A5A, 24'h0F0F0F, 10, 32, 1'b0, 1'b1, 1'b0};  // truncated left
    tbl[4] = '{24'hFFFFFF, 24'h000000, 32, 32, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{24'h13579B, 24'h2468AC, 32, 20, 1'b0, 1'b0, 1'b1};  // truncated right
    tbl[6] = '{24'hC0FFEE, 24'hBADC0D, 28, 30, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; bclk_in = 1'b0; lrclk_in = 1'b0; dout_in = 1'b0; out_ack = 1'b1;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stb", out_stb, 0);
    chk("rst_left", left_out, 0);
    chk("rst_right", right_out, 0);
    chk("rst_ovr", overrun_out, 0);
    chk("rst_ferr", frame_err_out, 0);
    for (int n = 0; n < 24; n++) begin
      chk("sclk", sclk_out, (n / SH) % 2);
      @(negedge clk);
    end

    // Table: per frame, pairs seen lag by one frame; right-slot errors land in the next frame
    pairs_before = 0;
    err_run = 0;
    for (int i = 0; i < 7; i++) begin
      send_frame(tbl[i], 1'b0);
      chk("tbl_pairs", n_obs, pairs_before);
      err_run += int'(tbl[i].exp_lerr) + ((i > 0) ? int'(tbl[i-1].exp_rerr) : 0);
      chk("tbl_errs", n_err, err_run);
      pairs_before += int'(tbl[i].exp_pair);
    end

    // Overrun: tbl[6] is held unacknowledged, fa arrives and is dropped
    out_ack = 1'b0;
    fa = rand_frame(1'b0); fa.exp_pair = 1'b0;
    fb = rand_frame(1'b0);
    send_frame(fa, 1'b0);
    send_frame(fb, 1'b0);
    chk("ovr_stb", out_stb, 1);
    chk("ovr_left", left_out, tbl[6].l);
    chk("ovr_right", right_out, tbl[6].r);
    chk("ovr_count", n_ovr, 1);

    // Ack lands in the same cycle fb completes: fb replaces the held pair
    fc = rand_frame(1'b0);
    send_frame(fc, 1'b1);
    chk("sim_stb", sim_stb, 1);
    chk("sim_left", sim_l, fb.l);
    chk("sim_right", sim_r, fb.r);
    chk("sim_no_ovr", n_ovr, 1);
    out_ack = 1'b1;
    tick(2);
    chk("ack_clears_stb", out_stb, 0);

    for (int i = 0; i < 12; i++) begin
      fr = rand_frame(1'b1);
      send_frame(fr, 1'b0);
    end

    // Reset in the middle of a right word
    send_slot(1'b0, W'($urandom), 32, 1'b0);
    send_slot(1'b1, W'($urandom), 12, 1'b0);
    n_obs_rst = n_obs;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    send_slot(1'b1, W'($urandom), 20, 1'b0);
    fd = rand_frame(1'b0);
    fe = rand_frame(1'b0);
    send_frame(fd, 1'b0);
    chk("rst_no_pair", n_obs, n_obs_rst);
    send_frame(fe, 1'b0);
    chk("rst_first_pair", n_obs, n_obs_rst + 1);
    send_slot(1'b0, W'($urandom), 32, 1'b0);
    tick(10);

    chk("all_pairs_seen", exp_q.size(), 0);
    chk("frame_err_total", n_err, exp_err_tot);
    chk("overrun_total", n_ovr, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
